// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS Avalon-MM bus arbiter.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUS_I,
        BUS_D
    } arb_state_t;

    typedef enum logic {
        GRANT_FETCH,
        GRANT_DATA
    } grant_t;

    localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/bus_wait_watchdog.sv
// Stall watchdog: counts waitrequest cycles within one bus transaction and
// flags expiry on the cycle whose stalled edge would be the WAIT_TIMEOUT-th.
module bus_wait_watchdog #(
    parameter int WAIT_TIMEOUT = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    localparam int CW = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(WAIT_TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (count_en && !expired)
            count <= count + 1'b1;
    end

    // Expiry is seen combinationally so the abort lands on the stalled edge itself.
    assign expired = (count == LAST);

endmodule

// File: rtl/mips_bus_arbiter.sv
// Avalon-MM arbiter sharing one master port between instruction fetch and data requesters.
// Build option MIPS_BUS_ARB_RR_EN: round-robin tie-break instead of fixed data priority.
//
// state | meaning
// IDLE  | no transaction; sample requests and grant at the next edge
// BUS_I | fetch read on the bus, waiting for waitrequest low
// BUS_D | data read/write on the bus, waiting for waitrequest low
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_address,
    output logic        if_done,
    output logic [31:0] if_readdata,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_address,
    input  logic [31:0] d_writedata,
    input  logic [3:0]  d_byteenable,
    output logic        d_done,
    output logic [31:0] d_readdata,
    output logic        bus_error,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);
    arb_state_t  state, state_nx;
    logic [31:0] address_nx, writedata_nx, if_readdata_nx, d_readdata_nx;
    logic [3:0]  byteenable_nx;
    logic        read_nx, write_nx, if_done_nx, d_done_nx, bus_error_nx;
    logic        d_req, prefer_data, grant_d, grant_i;
    logic        wd_clear, wd_count, wd_expired;

    assign d_req = d_read | d_write;

`ifdef MIPS_BUS_ARB_RR_EN
    grant_t last_grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_grant <= GRANT_FETCH;
        else if (grant_d)
            last_grant <= GRANT_DATA;
        else if (grant_i)
            last_grant <= GRANT_FETCH;
    end

    assign prefer_data = (last_grant == GRANT_FETCH);
`else
    assign prefer_data = 1'b1;
`endif

    assign grant_d  = (state == IDLE) && d_req && (!if_req || prefer_data);
    assign grant_i  = (state == IDLE) && if_req && !grant_d;
    assign wd_clear = (state == IDLE);
    assign wd_count = (state != IDLE) && waitrequest;

    bus_wait_watchdog #(
        .WAIT_TIMEOUT(WAIT_TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (wd_clear),
        .count_en (wd_count),
        .expired  (wd_expired)
    );

    always_comb begin
        state_nx       = state;
        address_nx     = address;
        writedata_nx   = writedata;
        byteenable_nx  = byteenable;
        read_nx        = read;
        write_nx       = write;
        if_readdata_nx = if_readdata;
        d_readdata_nx  = d_readdata;
        if_done_nx     = 1'b0;
        d_done_nx      = 1'b0;
        bus_error_nx   = 1'b0;

        case (state)
            IDLE: begin
                read_nx  = 1'b0;
                write_nx = 1'b0;
                if (grant_d) begin
                    address_nx    = d_address;
                    writedata_nx  = d_writedata;
                    byteenable_nx = d_byteenable;
                    read_nx       = d_read & ~d_write;
                    write_nx      = d_write;
                    state_nx      = BUS_D;
                end else if (grant_i) begin
                    address_nx    = if_address;
                    byteenable_nx = BE_WORD;
                    read_nx       = 1'b1;
                    state_nx      = BUS_I;
                end
            end
            BUS_I, BUS_D: begin
                if (!waitrequest || wd_expired) begin
                    state_nx = IDLE;
                    read_nx  = 1'b0;
                    write_nx = 1'b0;
                    if (state == BUS_I)
                        if_done_nx = 1'b1;
                    else
                        d_done_nx = 1'b1;
                    // Still stalled here means the watchdog fired: abort with zeroed data.
                    if (waitrequest) begin
                        bus_error_nx = 1'b1;
                        if (state == BUS_I)
                            if_readdata_nx = '0;
                        else
                            d_readdata_nx = '0;
                    end else if (state == BUS_I) begin
                        if_readdata_nx = readdata;
                    end else if (read) begin
                        d_readdata_nx = readdata;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            address     <= '0;
            writedata   <= '0;
            byteenable  <= 4'h0;
            read        <= 1'b0;
            write       <= 1'b0;
            if_readdata <= '0;
            d_readdata  <= '0;
            if_done     <= 1'b0;
            d_done      <= 1'b0;
            bus_error   <= 1'b0;
        end else begin
            state       <= state_nx;
            address     <= address_nx;
            writedata   <= writedata_nx;
            byteenable  <= byteenable_nx;
            read        <= read_nx;
            write       <= write_nx;
            if_readdata <= if_readdata_nx;
            d_readdata  <= d_readdata_nx;
            if_done     <= if_done_nx;
            d_done      <= d_done_nx;
            bus_error   <= bus_error_nx;
        end
    end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter: vector table of single transactions
// plus hand-written sequences for timeout, ties, dropped request and mid-transaction reset.
module tb_mips_bus_arbiter;

    localparam int WAIT_TIMEOUT = 8;
    localparam logic [1:0] K_FETCH = 2'd0;
    localparam logic [1:0] K_READ  = 2'd1;
    localparam logic [1:0] K_WRITE = 2'd2;
    localparam logic [1:0] K_BOTH  = 2'd3;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          nwait;
        logic [31:0] rdata;
        logic        exp_read;
        logic        exp_write;
        logic [3:0]  exp_be;
        logic        exp_if_done;
        logic        exp_d_done;
        logic [31:0] exp_if_rdata;
        logic [31:0] exp_d_rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_address;
    logic        if_done;
    logic [31:0] if_readdata;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_address;
    logic [31:0] d_writedata;
    logic [3:0]  d_byteenable;
    logic        d_done;
    logic [31:0] d_readdata;
    logic        bus_error;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    int n_cmp = 0;
    int n_err = 0;
    vec_t vecs[6];

    always #5 clk = ~clk;

    mips_bus_arbiter #(
        .WAIT_TIMEOUT(WAIT_TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .if_req       (if_req),
        .if_address   (if_address),
        .if_done      (if_done),
        .if_readdata  (if_readdata),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_writedata  (d_writedata),
        .d_byteenable (d_byteenable),
        .d_done       (d_done),
        .d_readdata   (d_readdata),
        .bus_error    (bus_error),
        .address      (address),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .byteenable   (byteenable),
        .waitrequest  (waitrequest),
        .readdata     (readdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Entered at posedge+1 with the DUT idle; returns at posedge+1 after the done cycle.
    task automatic run_txn(input vec_t v, input int idx);
        if_req       = (v.kind == K_FETCH);
        if_address   = v.addr;
        d_read       = (v.kind == K_READ) || (v.kind == K_BOTH);
        d_write      = (v.kind == K_WRITE) || (v.kind == K_BOTH);
        d_address    = v.addr;
        d_writedata  = v.wdata;
        d_byteenable = v.be;
        waitrequest  = (v.nwait != 0);
        readdata     = v.rdata;
        @(posedge clk); #1;
        for (int c = 0; c <= v.nwait; c++) begin
            if (c == v.nwait) waitrequest = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_c%0d_address", idx, c), address, v.addr);
            chk($sformatf("v%0d_c%0d_read", idx, c), 32'(read), 32'(v.exp_read));
            chk($sformatf("v%0d_c%0d_write", idx, c), 32'(write), 32'(v.exp_write));
            chk($sformatf("v%0d_c%0d_be", idx, c), 32'(byteenable), 32'(v.exp_be));
            chk($sformatf("v%0d_c%0d_dones", idx, c), 32'({if_done, d_done}), 32'(0));
            if (v.kind != K_FETCH)
                chk($sformatf("v%0d_c%0d_writedata", idx, c), writedata, v.wdata);
            @(posedge clk); #1;
        end
        if_req  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_if_done", idx), 32'(if_done), 32'(v.exp_if_done));
        chk($sformatf("v%0d_d_done", idx), 32'(d_done), 32'(v.exp_d_done));
        chk($sformatf("v%0d_if_readdata", idx), if_readdata, v.exp_if_rdata);
        chk($sformatf("v%0d_d_readdata", idx), d_readdata, v.exp_d_rdata);
        chk($sformatf("v%0d_rw_after", idx), 32'({read, write}), 32'(0));
        chk($sformatf("v%0d_bus_error", idx), 32'(bus_error), 32'(0));
        @(posedge clk); #1;
        chk($sformatf("v%0d_done_one_cycle", idx), 32'({if_done, d_done}), 32'(0));
    endtask

    task automatic tie_sequence();
        logic exp_d;
        int   w;
        if_req      = 1'b1;
        if_address  = 32'h0000_5000;
        d_read      = 1'b1;
        d_address   = 32'h0000_4000;
        d_byteenable = 4'hF;
        waitrequest = 1'b0;
        readdata    = 32'h1111_2222;
        for (int t = 0; t < 4; t++) begin
`ifdef MIPS_BUS_ARB_RR_EN
            exp_d = (t % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            w = 0;
            do begin
                @(negedge clk);
                w++;
                chk($sformatf("tie%0d_exclusive_done", t), 32'(if_done & d_done), 32'(0));
                if (!if_done && !d_done && (read || write))
                    chk($sformatf("tie%0d_grant_addr", t), address,
                        exp_d ? 32'h0000_4000 : 32'h0000_5000);
            end while (!(if_done || d_done) && w < 10);
            if (!(if_done || d_done)) begin
                n_cmp++;
                n_err++;
                $display("FAIL tie%0d_timeout: got no done in %0d cycles, expected a done", t, w);
            end
            chk($sformatf("tie%0d_granted_data", t), 32'(d_done), 32'(exp_d));
        end
        if_req = 1'b0;
        d_read = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int cnt;
        int w;
        int seen;

        //           kind     addr           wdata          be       nw rdata          rd wr be    ifd dd if_rdata       d_rdata
        vecs[0] = '{K_FETCH, 32'hBFC0_0000, 32'h0,         4'h0,    0, 32'h3C1D_0001, 1, 0, 4'hF, 1, 0, 32'h3C1D_0001, 32'h0};
        vecs[1] = '{K_WRITE, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011, 3, 32'h7777_7777, 0, 1, 4'h3, 0, 1, 32'h3C1D_0001, 32'h0};
        vecs[2] = '{K_READ,  32'h0000_2004, 32'h0,         4'hF,    1, 32'hCAFE_F00D, 1, 0, 4'hF, 0, 1, 32'h3C1D_0001, 32'hCAFE_F00D};
        vecs[3] = '{K_BOTH,  32'h0000_3000, 32'h1234_5678, 4'b1100, 0, 32'hFFFF_FFFF, 0, 1, 4'hC, 0, 1, 32'h3C1D_0001, 32'hCAFE_F00D};
        vecs[4] = '{K_FETCH, 32'h0040_0020, 32'h0,         4'h0,    2, 32'h8FA4_0000, 1, 0, 4'hF, 1, 0, 32'h8FA4_0000, 32'hCAFE_F00D};
        vecs[5] = '{K_READ,  32'h0000_2008, 32'h0,         4'h1,    7, 32'h0000_00A5, 1, 0, 4'h1, 0, 1, 32'h8FA4_0000, 32'h0000_00A5};

        reset = 1'b1;
        if_req = 1'b0; if_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_writedata = '0; d_byteenable = '0;
        waitrequest = 1'b0; readdata = '0;
        #22;
        chk("rst_rw", 32'({read, write}), 32'(0));
        chk("rst_dones", 32'({if_done, d_done, bus_error}), 32'(0));
        chk("rst_address", address, 32'h0);
        chk("rst_writedata", writedata, 32'h0);
        chk("rst_be", 32'(byteenable), 32'(0));
        chk("rst_readdata", if_readdata | d_readdata, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_no_req", 32'({read, write, if_done, d_done}), 32'(0));
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_txn(vecs[i], i);

        // Fetch stalled forever: watchdog aborts after WAIT_TIMEOUT stalled edges.
        if_req = 1'b1; if_address = 32'h0000_0010; waitrequest = 1'b1; readdata = 32'h5555_5555;
        cnt = 0; w = 0;
        @(posedge clk); #1;
        do begin
            @(negedge clk);
            w++;
            if (!if_done && read) cnt++;
        end while (!if_done && w < 20);
        if_req = 1'b0;
        waitrequest = 1'b0;
        chk("to_read_cycles", 32'(cnt), 32'(WAIT_TIMEOUT));
        chk("to_if_done", 32'(if_done), 32'(1));
        chk("to_bus_error", 32'(bus_error), 32'(1));
        chk("to_read_dropped", 32'(read), 32'(0));
        chk("to_if_readdata", if_readdata, 32'h0);
        chk("to_d_done", 32'(d_done), 32'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("to_bus_error_pulse", 32'(bus_error), 32'(0));
        @(posedge clk); #1;

        tie_sequence();

        // Request dropped after grant still completes.
        d_read = 1'b1; d_address = 32'h0000_7000; d_byteenable = 4'hF;
        waitrequest = 1'b1; readdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        d_read = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        waitrequest = 1'b0;
        seen = 0; w = 0;
        do begin
            @(negedge clk);
            w++;
            if (d_done) seen++;
        end while (seen == 0 && w < 10);
        chk("drop_d_done", 32'(seen), 32'(1));
        chk("drop_d_readdata", d_readdata, 32'h0BAD_F00D);
        @(posedge clk); #1;

        // Reset in BUS_D while stalled.
        d_write = 1'b1; d_address = 32'h0000_6000; d_writedata = 32'hA5A5_A5A5; d_byteenable = 4'hF;
        waitrequest = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid_write_before", 32'(write), 32'(1));
        #2 reset = 1'b1;
        #1;
        chk("rstmid_write_async", 32'(write), 32'(0));
        chk("rstmid_address", address, 32'h0);
        d_write = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        waitrequest = 1'b0;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (d_done || write) seen++;
        end
        chk("rstmid_no_done", 32'(seen), 32'(0));
        @(posedge clk); #1;
        run_txn('{K_FETCH, 32'h0000_0100, 32'h0, 4'h0, 0, 32'h2408_0001,
                  1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 32'h2408_0001, 32'h0}, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
